// File: rtl/echo_initiator.sv
// echo_initiator: sends a numbered byte sequence to a transmitter and
// checks each echo from the receiver, counting mismatches and timeouts.
module echo_initiator #(
    parameter int         N_BYTES        = 16,
    parameter logic [7:0] START_BYTE     = 8'h41,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_rdy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       timeout
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      IDX_LAST = 8'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    err_q, err_d;
    logic          tmo_q, tmo_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          rx_prev_q, rx_prev_d;

    logic          rx_edge;
    logic          tmo_hit;
    logic          last_byte;
    logic          err_inc;
    logic [7:0]    exp_byte;

    assign rx_edge   = rx_valid & ~rx_prev_q;
    assign tmo_hit   = (tcnt_q == T_LAST);
    assign last_byte = (idx_q == IDX_LAST);
    assign exp_byte  = START_BYTE + idx_q;
    assign rx_prev_d = rx_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'h00;
            tcnt_q    <= '0;
            err_q     <= 8'h00;
            tmo_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            rx_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_SEND;
            S_SEND:         if (tx_rdy) state_d = S_WAIT;
            S_WAIT: begin
                if (rx_edge || tmo_hit)
                    state_d = last_byte ? S_DONE : S_SEND;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    // An echo edge takes priority over a timeout landing in the same cycle.
    always_comb begin
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        err_inc   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d  = 8'h00;
                    tcnt_d = '0;
                    err_d  = 8'h00;
                    tmo_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (rx_edge) err_inc = 1'b1;
                if (tx_rdy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = exp_byte;
                    tcnt_d    = '0;
                end
            end
            S_WAIT: begin
                if (rx_edge) begin
                    if (rx_data != exp_byte) err_inc = 1'b1;
                    if (!last_byte) idx_d = idx_q + 8'd1;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    err_inc = 1'b1;
                    if (!last_byte) idx_d = idx_q + 8'd1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
        if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_comb begin
        busy = (state_q == S_SEND) || (state_q == S_WAIT);
        done = (state_q == S_DONE);
        pass = (state_q == S_DONE) && (err_q == 8'h00);
    end

    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign err_count = err_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_echo_initiator.sv
// tb_echo_initiator: directed checks of echo_initiator with a loopback
// responder (4-byte instance) and a no-echo saturation instance.
module tb_echo_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         n_run = 0;
    int         n_fail = 0;
    int         cyc = 0;

    logic       start_a = 1'b0, tx_rdy_a = 1'b1;
    logic       tx_en_a, busy_a, done_a, pass_a, tmo_a;
    logic [7:0] tx_data_a, err_a;
    logic       resp_v = 1'b0, stray_v = 1'b0;
    logic [7:0] rx_data_a = 8'h00;
    logic       rx_valid_a;

    logic       start_b = 1'b0, tx_rdy_b = 1'b1;
    logic       rx_valid_b = 1'b0;
    logic [7:0] rx_data_b = 8'h00;
    logic       tx_en_b, busy_b, done_b, pass_b, tmo_b;
    logic [7:0] tx_data_b, err_b;

    assign rx_valid_a = resp_v | stray_v;

    always #5 clk = ~clk;

    echo_initiator #(
        .N_BYTES(4), .START_BYTE(8'h41), .TIMEOUT_CYCLES(100)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_rdy(tx_rdy_a),
        .tx_en(tx_en_a), .tx_data(tx_data_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .timeout(tmo_a)
    );

    echo_initiator #(
        .N_BYTES(256), .START_BYTE(8'hFE), .TIMEOUT_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_rdy(tx_rdy_b),
        .tx_en(tx_en_b), .tx_data(tx_data_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .timeout(tmo_b)
    );

    logic [7:0] tx_log [0:63];
    int         tx_cyc [0:63];
    int         tx_cnt_a = 0;
    logic [7:0] b_log [0:3];
    logic [7:0] b_last = 8'h00;
    int         tx_cnt_b = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (tx_en_a && tx_cnt_a < 64) begin
            tx_log[tx_cnt_a] = tx_data_a;
            tx_cyc[tx_cnt_a] = cyc;
            tx_cnt_a++;
        end
        if (tx_en_b) begin
            if (tx_cnt_b < 4) b_log[tx_cnt_b] = tx_data_b;
            b_last = tx_data_b;
            tx_cnt_b++;
        end
    end

    // mode: 0 = echo the byte, 1 = echo 8'h00, 2 = stay silent
    int mode [0:3];
    int run_base = 0;
    int served = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (served < tx_cnt_a) begin
                automatic int k = served - run_base;
                automatic int m = (k >= 0 && k < 4) ? mode[k] : 0;
                automatic logic [7:0] b = tx_log[served];
                served++;
                repeat (19) @(negedge clk);
                if (m != 2) begin
                    rx_data_a = (m == 1) ? 8'h00 : b;
                    resp_v = 1'b1;
                    repeat (2) @(negedge clk);
                    resp_v = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go_a();
        run_base = tx_cnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_a, 1);
    endtask

    task automatic set_mode(input int m0, input int m1,
                            input int m2, input int m3);
        mode[0] = m0;
        mode[1] = m1;
        mode[2] = m2;
        mode[3] = m3;
    endtask

    initial begin
        int lo_bad, busy_bad, n, cnt0;
        set_mode(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_tx_en", tx_en_a, 0);
        chk("rst_tx_data", tx_data_a, 8'h00);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_tmo", tmo_a, 0);
        chk("rst_b_done", done_b, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // loopback
        go_a();
        chk("loop_busy", busy_a, 1);
        wait_done_a("loop_done");
        for (int i = 0; i < 4; i++)
            chk($sformatf("loop_byte%0d", i), tx_log[run_base + i], 8'h41 + i);
        chk("loop_pass", pass_a, 1);
        chk("loop_err", err_a, 0);
        chk("loop_tmo", tmo_a, 0);
        chk("loop_busy_end", busy_a, 0);
        repeat (5) @(negedge clk);
        chk("loop_hold_done", done_a, 1);

        // corrupted third echo
        set_mode(0, 0, 1, 0);
        go_a();
        chk("corr_clear", err_a, 0);
        wait_done_a("corr_done");
        chk("corr_pass", pass_a, 0);
        chk("corr_err", err_a, 1);
        chk("corr_tmo", tmo_a, 0);
        repeat (5) @(negedge clk);

        // silent second byte -> timeout
        set_mode(0, 2, 0, 0);
        go_a();
        wait_done_a("tmo_done");
        chk("tmo_flag", tmo_a, 1);
        chk("tmo_err", err_a, 1);
        chk("tmo_pass", pass_a, 0);
        chk("tmo_gap", tx_cyc[run_base + 2] - tx_cyc[run_base + 1], 101);
        chk("tmo_byte2", tx_log[run_base + 2], 8'h43);
        repeat (5) @(negedge clk);

        // backpressure plus a stray byte in SEND
        set_mode(0, 0, 0, 0);
        tx_rdy_a = 1'b0;
        go_a();
        chk("bp_clear_tmo", tmo_a, 0);
        lo_bad = 0;
        busy_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_en_a) lo_bad++;
            if (!busy_a) busy_bad++;
            @(negedge clk);
        end
        chk("bp_tx_low", lo_bad, 0);
        chk("bp_busy", busy_bad, 0);
        stray_v = 1'b1;
        repeat (2) @(negedge clk);
        stray_v = 1'b0;
        @(negedge clk);
        chk("stray_err", err_a, 1);
        tx_rdy_a = 1'b1;
        @(negedge clk);
        chk("bp_pulse", tx_en_a, 1);
        chk("bp_pulse_data", tx_data_a, 8'h41);
        @(negedge clk);
        chk("bp_pulse_end", tx_en_a, 0);
        chk("bp_data_hold", tx_data_a, 8'h41);
        wait_done_a("bp_done");
        chk("bp_err", err_a, 1);
        chk("bp_pass", pass_a, 0);
        repeat (5) @(negedge clk);

        // reset while waiting for the second echo
        go_a();
        n = 0;
        while (tx_cnt_a < run_base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach", tx_cnt_a - run_base, 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_busy", busy_a, 0);
        chk("mid_tx_data", tx_data_a, 8'h00);
        chk("mid_tx_en", tx_en_a, 0);
        chk("mid_err", err_a, 0);
        chk("mid_done", done_a, 0);
        cnt0 = tx_cnt_a;
        repeat (40) @(negedge clk);
        chk("mid_no_tx", tx_cnt_a, cnt0);
        chk("mid_idle_err", err_a, 0);
        go_a();
        wait_done_a("mid_done2");
        chk("mid_first", tx_log[run_base], 8'h41);
        chk("mid_pass", pass_a, 1);

        // 256 silent bytes from 8'hFE
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_done", done_b, 1);
        chk("sat_count", tx_cnt_b, 256);
        chk("sat_b0", b_log[0], 8'hFE);
        chk("sat_b1", b_log[1], 8'hFF);
        chk("sat_b2", b_log[2], 8'h00);
        chk("sat_b3", b_log[3], 8'h01);
        chk("sat_last", b_last, 8'hFD);
        chk("sat_err", err_b, 8'hFF);
        chk("sat_tmo", tmo_b, 1);
        chk("sat_pass", pass_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_initiator.md
ECHO_INITIATOR -- requirements
Module: echo_initiator

Interface
REQ-001 SHALL have parameter N_BYTES, default 16, number of bytes sent per test run (1..256).
REQ-002 SHALL have parameter START_BYTE, default 8'h41, value of the first byte sent.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, clk cycles allowed per echo (>=2).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  level; sampled high in IDLE or DONE begins a run.
REQ-007 SHALL have port tx_rdy  input  1  byte transmitter ready to accept a byte.
REQ-008 SHALL have port tx_en  output  1  one-cycle request to the transmitter.
REQ-009 SHALL have port tx_data  output  8  byte presented with tx_en.
REQ-010 SHALL have port rx_valid  input  1  receiver valid; rising edge marks a new byte.
REQ-011 SHALL have port rx_data  input  8  received byte, stable while rx_valid high.
REQ-012 SHALL have port busy  output  1  high in SEND and WAIT_ECHO.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port pass  output  1  high in DONE when err_count == 0.
REQ-015 SHALL have port err_count  output  8  errors in current/last run, saturating at 255.
REQ-016 SHALL have port timeout  output  1  sticky; set on any echo timeout in current/last run.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT_ECHO, DONE.
REQ-018 IDLE/DONE with start=1 SHALL clear err_count, timeout, byte index idx=0 and enter SEND next cycle; start is ignored while busy.
REQ-019 SEND with tx_rdy=1 SHALL drive tx_en=1 for exactly one cycle with tx_data = (START_BYTE + idx) mod 256, then enter WAIT_ECHO and clear the timeout counter.
REQ-020 SEND with tx_rdy=0 SHALL hold tx_en=0 and remain in SEND indefinitely (no timeout in SEND).
REQ-021 tx_data SHALL hold its last driven value when tx_en=0.
REQ-022 rx_valid rising edge SHALL be detected with one registered copy of rx_valid; a level held high counts once.
REQ-023 WAIT_ECHO on rx_valid rising edge SHALL compare rx_data to the expected byte; mismatch increments err_count.
REQ-024 WAIT_ECHO timeout counter SHALL increment every cycle; on reaching TIMEOUT_CYCLES-1 with no edge, SHALL set timeout and increment err_count.
REQ-025 Edge and timeout in the same cycle: edge SHALL win, timeout not flagged.
REQ-026 After an edge or timeout in WAIT_ECHO: if idx == N_BYTES-1 enter DONE, else idx+1 and enter SEND.
REQ-027 rx_valid rising edge while in SEND (stray byte) SHALL increment err_count; edges in IDLE/DONE SHALL be ignored.
REQ-028 err_count SHALL saturate at 8'hFF, never wrap.
REQ-029 Byte value wrap: START_BYTE + idx SHALL wrap modulo 256 (e.g. START_BYTE=8'hFE, idx=2 -> 8'h00).
REQ-030 done, pass, err_count, timeout SHALL hold their values in DONE until the next start.

Reset
REQ-031 rst=0 at a rising clk edge SHALL force IDLE, tx_en=0, tx_data=8'h00, busy=0, done=0, pass=0, err_count=0, timeout=0, idx=0, timeout counter=0, rx_valid history=0, regardless of state.
REQ-032 Reset asserted mid-run SHALL abort the run with no further tx_en pulse; first start after release begins a fresh run.

Verification
REQ-033 Loopback: N_BYTES=4, START_BYTE=8'h41, echo each byte 20 cycles after tx_en -> tx_data 41,42,43,44; done=1, pass=1, err_count=0, timeout=0.
REQ-034 Corruption: echo byte 3 as 8'h00 -> done=1, pass=0, err_count=1, timeout=0.
REQ-035 Timeout: TIMEOUT_CYCLES=100, no echo for byte 2 -> timeout=1, err_count=1, byte 3 sent ~100 cycles after byte 2, run completes.
REQ-036 Backpressure: tx_rdy=0 for 50 cycles in SEND -> tx_en stays 0, busy=1; tx_en pulses once the cycle after tx_rdy rises.
REQ-037 Saturation/wrap: N_BYTES=256, START_BYTE=8'hFE, no echoes, TIMEOUT_CYCLES=2 -> tx_data sequence FE,FF,00,...; err_count=255 at DONE.
REQ-038 Reset mid-run: rst=0 during WAIT_ECHO of byte 2 -> all outputs at reset values next cycle; start then resends 8'h41 first.
